otter_fetch_unit: RTL

- Instruction-fetch stage of the pipelined OTTER MCU. It sits directly upstream of the decode IR/PC registers.
- Owns the program counter and drives instruction-memory port 1, which is a synchronous read with 1-cycle latency.
- Buffers returned instructions in a small FIFO. Presents them to decode with a valid/stall handshake.
- Supports redirect (branch/jump/trap) by flushing buffered and in-flight fetches.

---
 rtl/otter_fetch_unit_if.sv | 24 ++
 rtl/otter_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/otter_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port 1 plus the decode-side
// valid/stall handshake and redirect request.
interface otter_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    output imem_addr, imem_rd, if_valid, if_ir, if_pc, if_pc4,
    input  imem_dout, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_addr, imem_rd, if_valid, if_ir, if_pc, if_pc4,
    output imem_dout, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: owns the PC, issues 1-cycle-latency reads and
// buffers returned words in a small FIFO presented to decode.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  otter_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  logic [31:0]   pc_r;
  logic [31:0]   req_pc_r;
  logic          inflight_r;
  logic          kill_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [31:0]   ir_mem_r [DEPTH];
  logic [31:0]   pc_mem_r [DEPTH];

  logic          not_empty_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;
  logic [31:0]   addr_s;
  logic [31:0]   head_pc_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_MAX) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Handshake, occupancy and issue decision
  always_comb begin
    not_empty_s = (count_r != {CW{1'b0}});
    valid_s     = not_empty_s & ~bus.redirect;
    pop_s       = valid_s & ~bus.stall;
    push_s      = inflight_r & ~kill_r;
    // pop implies count >= 1, so this never underflows
    occ_s       = {1'b0, count_r} + (CW + 1)'(inflight_r) - (CW + 1)'(pop_s);
    issue_s     = rst_n & (bus.redirect | (occ_s < DEPTH_W));
    if (bus.redirect) begin
      addr_s = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      addr_s = pc_r;
    end
    if (not_empty_s) begin
      head_pc_s = pc_mem_r[rd_ptr_r];
    end else begin
      head_pc_s = 32'h0000_0000;
    end
  end

  assign bus.imem_rd   = issue_s;
  assign bus.imem_addr = addr_s;
  assign bus.if_valid  = valid_s;
  assign bus.if_ir     = not_empty_s ? ir_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.if_pc     = head_pc_s;
  assign bus.if_pc4    = head_pc_s + 32'd4;

  // Program counter and in-flight request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_VEC;
      req_pc_r   <= 32'h0000_0000;
      inflight_r <= 1'b0;
      kill_r     <= 1'b0;
    end else begin
      if (issue_s) begin
        req_pc_r   <= addr_s;
        pc_r       <= addr_s + 32'd4;
        inflight_r <= 1'b1;
      end else begin
        inflight_r <= 1'b0;
      end
      // a redirect always issues its own fetch, so its response is kept
      kill_r <= bus.redirect & ~issue_s;
    end
  end

  // Buffer pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else if (bus.redirect) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Buffer storage: instruction word with the address it was fetched from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s && !bus.redirect) begin
      ir_mem_r[wr_ptr_r] <= bus.imem_dout;
      pc_mem_r[wr_ptr_r] <= req_pc_r;
    end else begin
      ir_mem_r[wr_ptr_r] <= ir_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r] <= pc_mem_r[wr_ptr_r];
    end
  end

endmodule
